mem_responder: RTL and testbench

Memory-side responder for the multicycle RV32 core's single-port bus (`address`, `data_out`, `data_in`, `we`). It decodes each access into on-chip RAM or a small MMIO region:
- a console transmit FIFO with a ready/valid drain port;
- a free-running cycle counter;
- a halt/exit-code register used by simulation benches.

Reads are combinational so the core can latch read data at the clock edge that ends its access cycle.

---
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the RV32 core bus: on-chip RAM plus console FIFO,
// cycle counter and halt/exit-code MMIO registers. Reads are combinational.
module mem_responder #(
   parameter int MEM_WORDS  = 4096,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt,
   output logic [31:0] exit_code
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [31:0]   mem_q [MEM_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   cycle_q, cycle_d;
   logic          halt_q, halt_d;
   logic [31:0]   exit_code_q, exit_code_d;

   logic ram_sel, mmio_sel, con_data_sel, con_stat_sel, cycle_sel, halt_sel;
   logic full, empty, pop, push_req, push;
   logic unused_addr;

   // Byte lane bits are meaningless on this word-only bus.
   assign unused_addr  = ^address[1:0];

   assign ram_sel      = (address[31:AW+2] == '0);
   assign mmio_sel     = (address[31:4] == 28'h100_0000);
   assign con_data_sel = mmio_sel && (address[3:2] == 2'd0);
   assign con_stat_sel = mmio_sel && (address[3:2] == 2'd1);
   assign cycle_sel    = mmio_sel && (address[3:2] == 2'd2);
   assign halt_sel     = mmio_sel && (address[3:2] == 2'd3);

   assign empty    = (count_q == '0);
   assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
   assign tx_valid = !empty;
   assign pop      = tx_valid && tx_ready;
   assign push_req = we && con_data_sel;
   // A full FIFO still accepts a byte when the head leaves in the same edge.
   assign push     = push_req && (!full || pop);

   assign tx_data   = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;
   assign halt      = halt_q;
   assign exit_code = exit_code_q;

   always_comb begin
      rdata = 32'h0;
      if (ram_sel)
         rdata = mem_q[address[AW+1:2]];
      else if (con_stat_sel)
         rdata = {16'h0, 8'(count_q), 5'b0, overflow_q, full, empty};
      else if (cycle_sel)
         rdata = cycle_q;
      else if (halt_sel)
         rdata = {31'b0, halt_q};
   end

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      cycle_d     = cycle_q + 32'd1;
      halt_d      = halt_q;
      exit_code_d = exit_code_q;
      if (pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
      if (push)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
      if (push_req && !push)
         overflow_d = 1'b1;
      if (we && con_stat_sel && wdata[2])
         overflow_d = 1'b0;
      if (we && cycle_sel)
         cycle_d = wdata;
      if (we && halt_sel) begin
         halt_d      = 1'b1;
         exit_code_d = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         cycle_q     <= 32'h0;
         halt_q      <= 1'b0;
         exit_code_q <= 32'h0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         cycle_q     <= cycle_d;
         halt_q      <= halt_d;
         exit_code_q <= exit_code_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we && ram_sel)
         mem_q[address[AW+1:2]] <= wdata;
   end

   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
         if (push && (wr_ptr_q == PW'(gi)))
            fifo_q[gi] <= wdata[7:0];
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table for bus reads plus a
// byte scoreboard that follows every console push and checks every pop.
module tb_mem_responder;
   localparam logic [31:0] CON  = 32'h1000_0000;
   localparam logic [31:0] STAT = 32'h1000_0004;
   localparam logic [31:0] CYC  = 32'h1000_0008;
   localparam logic [31:0] HLT  = 32'h1000_000C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        we = 1'b0;
   logic [31:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        halt;
   logic [31:0] exit_code;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];
   int m_cnt = 0;

   always #5 clk = ~clk;

   mem_responder #(.MEM_WORDS(4096), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .address(address), .wdata(wdata), .we(we),
      .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .halt(halt), .exit_code(exit_code)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else
         $display("[TB] ok %s = 0x%08h", name, act);
   endtask

   // Inputs are stable from posedge+1 through the next posedge, so the
   // negedge sees exactly what the coming edge will act upon.
   always @(negedge clk) begin
      logic do_pop, do_push;
      if (reset) begin
         exp_q.delete();
         m_cnt = 0;
      end else begin
         chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_cnt != 0});
         do_pop  = (m_cnt != 0) && tx_ready;
         do_push = we && (address == CON) && (m_cnt < 8 || do_pop);
         if (do_pop) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL pop: unexpected byte 0x%02h", tx_data);
            end else
               chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
         end
         if (do_push)
            exp_q.push_back(wdata[7:0]);
         m_cnt = m_cnt + int'(do_push) - int'(do_pop);
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        w;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_halt;
      logic [31:0] exp_exit;
   } vec_t;

   task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
      address = a; wdata = d; we = w;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      address = a; we = 1'b0;
      #1 chk(name, rdata, exp);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(32'h2000_0000, 32'h0, 1'b0);
   endtask

   vec_t vecs[$];

   initial begin
      vecs = '{
         '{32'h40,        32'hCAFEBABE, 1, 0, 32'h0,        0, 32'h0},
         '{32'h40,        32'h0,        0, 1, 32'hCAFEBABE, 0, 32'h0},
         '{32'h43,        32'h0,        0, 1, 32'hCAFEBABE, 0, 32'h0},
         '{STAT,          32'h0,        0, 1, 32'h1,        0, 32'h0},
         '{32'h2000_0000, 32'hDEADBEEF, 1, 1, 32'h0,        0, 32'h0},
         '{32'h2000_0000, 32'h0,        0, 1, 32'h0,        0, 32'h0},
         '{32'h4000,      32'h12345678, 1, 1, 32'h0,        0, 32'h0},
         '{32'h4000,      32'h0,        0, 1, 32'h0,        0, 32'h0},
         '{HLT,           32'h0,        0, 1, 32'h0,        0, 32'h0},
         '{CON,           32'h48,       1, 1, 32'h0,        0, 32'h0},
         '{CON,           32'h69,       1, 1, 32'h0,        0, 32'h0},
         '{STAT,          32'h0,        0, 1, 32'h0200,     0, 32'h0},
         '{CON,           32'h0,        0, 1, 32'h0,        0, 32'h0},
         '{32'h44,        32'h11112222, 1, 0, 32'h0,        0, 32'h0},
         '{32'h44,        32'h33334444, 1, 1, 32'h11112222, 0, 32'h0},
         '{32'h44,        32'h0,        0, 1, 32'h33334444, 0, 32'h0},
         '{HLT,           32'h2A,       1, 1, 32'h0,        0, 32'h0},
         '{HLT,           32'h0,        0, 1, 32'h1,        1, 32'h2A},
         '{HLT,           32'h7,        1, 1, 32'h1,        1, 32'h2A},
         '{HLT,           32'h0,        0, 1, 32'h1,        1, 32'h7}
      };

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_halt", {31'b0, halt}, 32'h0);
      chk("rst_exit", exit_code, 32'h0);

      foreach (vecs[i]) begin
         address = vecs[i].addr; wdata = vecs[i].data; we = vecs[i].w;
         #1;
         if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
         chk($sformatf("vec%0d_halt", i), {31'b0, halt}, {31'b0, vecs[i].exp_halt});
         chk($sformatf("vec%0d_exit", i), exit_code, vecs[i].exp_exit);
         @(posedge clk); #1;
         we = 1'b0;
      end

      // Drain "Hi"
      tx_ready = 1'b1;
      idle(4);
      tx_ready = 1'b0;
      rd("drained_status", STAT, 32'h1);

      // Overflow: nine bytes into an eight-entry FIFO
      for (int k = 0; k < 9; k++) step(CON, 32'h30 + k, 1'b1);
      rd("ovf_status", STAT, 32'h0806);
      step(STAT, 32'h4, 1'b1);
      rd("ovf_clear", STAT, 32'h0802);

      // Push and pop in the same cycle while full
      tx_ready = 1'b1;
      step(CON, 32'h55, 1'b1);
      tx_ready = 1'b0;
      rd("full_pushpop", STAT, 32'h0802);
      tx_ready = 1'b1;
      idle(12);
      tx_ready = 1'b0;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d bytes never emerged, required 0", exp_q.size());
      end
      rd("full_drained", STAT, 32'h1);

      // Cycle counter load and wrap
      step(CYC, 32'hFFFF_FFFE, 1'b1);
      rd("cyc_load", CYC, 32'hFFFF_FFFE);
      rd("cyc_max", CYC, 32'hFFFF_FFFF);
      rd("cyc_wrap", CYC, 32'h0);

      // Reset mid-drain with 3 bytes queued, overflow set, halt set
      for (int k = 0; k < 9; k++) step(CON, 32'h61 + k, 1'b1);
      tx_ready = 1'b1;
      idle(5);
      rd("pre_rst_status", STAT, 32'h0304);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      tx_ready = 1'b0;
      chk("post_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("post_rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("post_rst_halt", {31'b0, halt}, 32'h0);
      chk("post_rst_exit", exit_code, 32'h0);
      rd("post_rst_cyc0", CYC, 32'h0);
      rd("post_rst_cyc1", CYC, 32'h1);
      rd("post_rst_status", STAT, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
